system_stack_unit: RTL and testbench

- Hardware data stack of the processor.
- Owns the stack-pointer register and the stack RAM.
- Executes the 2-bit stack operation issued by the decode stage each cycle.
- Downstream of the SP-update arithmetic: it consumes the same operation encoding, but guards overflow and underflow instead of silently wrapping.
- Returns popped words to the ALU-operand path.

---
 rtl/system_stack_unit_pkg.sv | 12 +
 rtl/system_stack_unit_ram.sv | 36 +++
 rtl/system_stack_unit.sv | 98 +++++++++
 tb/tb_system_stack_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/system_stack_unit_pkg.sv
// Shared processor constants for the data stack: widths and the 2-bit
// stack operation encoding used by decode, SP-update logic and the stack unit.
package system_stack_unit_pkg;

  localparam int SP_W   = 7;
  localparam int DATA_W = 16;

  localparam logic [1:0] STACK_OP_NOP  = 2'b00;
  localparam logic [1:0] STACK_OP_PUSH = 2'b01;
  localparam logic [1:0] STACK_OP_POP  = 2'b10;

endpackage

// File: rtl/system_stack_unit_ram.sv
// Single-port synchronous stack RAM with write enable and a registered read
// port. The read register only loads on a read so it holds the last popped word.
module system_stack_unit_ram
  import system_stack_unit_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = SP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W_P-1:0] addr,
  input  logic [DATA_W_P-1:0] wdata,
  output logic [DATA_W_P-1:0] rdata
);

  logic [DATA_W_P-1:0] mem [0:(1<<ADDR_W_P)-1];

  // Array write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read data; loads only on a read so it holds between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/system_stack_unit.sv
// Hardware data stack: stack-pointer register, overflow/underflow guards,
// sticky error flags and the one-cycle pop result pipeline.
// Ops are issued one per cycle with no handshake: stack_op_i is acted on at
// every rising edge, and pop_valid_o is a one-cycle pulse qualifying
// pop_data_o with no back-pressure from the consumer.
module system_stack_unit
  import system_stack_unit_pkg::*;
#(
  parameter int DATA_W = system_stack_unit_pkg::DATA_W,
  parameter int SP_W   = system_stack_unit_pkg::SP_W
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [1:0]        stack_op_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              clr_i,
  output logic [SP_W-1:0]   sp_o,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              pop_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              udf_o
);

  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_next;
  logic [SP_W-1:0] ram_addr;
  logic            is_push;
  logic            is_pop;
  logic            do_push;
  logic            do_pop;
  logic            full;
  logic            empty;

  assign full  = (sp == {SP_W{1'b1}});
  assign empty = (sp == '0);

  // Decode the op and apply the full/empty guards; clear discards the op.
  always_comb begin
    is_push = !clr_i && (stack_op_i == STACK_OP_PUSH);
    is_pop  = !clr_i && (stack_op_i == STACK_OP_POP);
    do_push = is_push && !full;
    do_pop  = is_pop && !empty;
  end

  // Next stack pointer and RAM address: pop reads the top at sp-1, push writes sp.
  always_comb begin
    sp_next  = sp;
    ram_addr = sp;
    if (clr_i) begin
      sp_next = '0;
    end else if (do_push) begin
      sp_next = sp + SP_W'(1);
    end else if (do_pop) begin
      sp_next  = sp - SP_W'(1);
      ram_addr = sp - SP_W'(1);
    end
  end

  // Stack pointer, sticky overflow/underflow flags and pop-valid pulse.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      sp          <= '0;
      ovf_o       <= 1'b0;
      udf_o       <= 1'b0;
      pop_valid_o <= 1'b0;
    end else begin
      sp          <= sp_next;
      pop_valid_o <= do_pop;
      if (clr_i) begin
        ovf_o <= 1'b0;
        udf_o <= 1'b0;
      end else begin
        if (is_push && full) ovf_o <= 1'b1;
        if (is_pop && empty) udf_o <= 1'b1;
      end
    end
  end

  system_stack_unit_ram #(
    .DATA_W_P(DATA_W),
    .ADDR_W_P(SP_W)
  ) u_ram (
    .clk   (system1000),
    .rst_n (system1000_rstn),
    .we    (do_push),
    .re    (do_pop),
    .addr  (ram_addr),
    .wdata (push_data_i),
    .rdata (pop_data_o)
  );

  assign sp_o    = sp;
  assign empty_o = empty;
  assign full_o  = full;

endmodule

// File: tb/tb_system_stack_unit.sv
// Directed bench for the data stack: stimulus tasks push expected pop words
// into a queue, a negedge monitor pops and compares on every pop_valid_o.
module tb_system_stack_unit;
  import system_stack_unit_pkg::*;

  localparam int DW = 16;
  localparam int SW = 7;

  logic          clk;
  logic          rstn;
  logic [1:0]    stack_op;
  logic [DW-1:0] push_data;
  logic          clr;
  logic [SW-1:0] sp;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          udf;

  logic [DW-1:0] exp_q[$];
  int            vectors;
  int            miscompares;

  system_stack_unit #(.DATA_W(DW), .SP_W(SW)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .stack_op_i      (stack_op),
    .push_data_i     (push_data),
    .clr_i           (clr),
    .sp_o            (sp),
    .pop_data_o      (pop_data),
    .pop_valid_o     (pop_valid),
    .empty_o         (empty),
    .full_o          (full),
    .ovf_o           (ovf),
    .udf_o           (udf)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every pop_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (pop_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pop_unexpected: got pop_data=%h with no pop outstanding", pop_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (pop_data !== e) begin
          miscompares++;
          $display("FAIL pop_data: got %h expected %h", pop_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    stack_op  = STACK_OP_PUSH;
    push_data = d;
    tick();
    stack_op  = STACK_OP_NOP;
  endtask

  task automatic do_pop(input logic [DW-1:0] expect_word);
    exp_q.push_back(expect_word);
    stack_op = STACK_OP_POP;
    tick();
    stack_op = STACK_OP_NOP;
  endtask

  task automatic do_pop_empty();
    stack_op = STACK_OP_POP;
    tick();
    stack_op = STACK_OP_NOP;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    stack_op    = STACK_OP_NOP;
    push_data   = '0;
    clr         = 1'b0;
    #12 rstn = 1'b1;

    // Reset then idle 3 cycles
    repeat (3) tick();
    check("reset_sp", 32'(sp), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_udf", 32'(udf), 32'd0);
    check("reset_pop_valid", 32'(pop_valid), 32'd0);
    check("reset_pop_data", 32'(pop_data), 32'd0);

    // LIFO order, back-to-back pops
    do_push(16'h1111);
    do_push(16'h2222);
    do_push(16'h3333);
    check("sp_after_3_push", 32'(sp), 32'd3);
    do_pop(16'h3333);
    check("b2b_pop1_valid", 32'(pop_valid), 32'd1);
    do_pop(16'h2222);
    check("b2b_pop2_valid", 32'(pop_valid), 32'd1);
    do_pop(16'h1111);
    check("b2b_pop3_valid", 32'(pop_valid), 32'd1);
    check("b2b_pop3_data", 32'(pop_data), 32'h1111);
    check("sp_after_pops", 32'(sp), 32'd0);
    check("empty_after_pops", 32'(empty), 32'd1);
    tick();
    check("pop_valid_one_cycle", 32'(pop_valid), 32'd0);
    check("pop_data_hold", 32'(pop_data), 32'h1111);

    // Underflow
    do_pop_empty();
    check("udf_sp", 32'(sp), 32'd0);
    check("udf_pop_valid", 32'(pop_valid), 32'd0);
    check("udf_set", 32'(udf), 32'd1);
    check("udf_pop_data_hold", 32'(pop_data), 32'h1111);
    tick();
    check("udf_sticky", 32'(udf), 32'd1);
    do_clr();
    check("udf_cleared", 32'(udf), 32'd0);

    // Fill to capacity, then overflow
    for (int i = 0; i < 127; i++) begin
      do_push(16'(i));
    end
    check("full_flag", 32'(full), 32'd1);
    check("full_sp", 32'(sp), 32'd127);
    check("full_ovf_clear", 32'(ovf), 32'd0);
    do_push(16'hBEEF);
    check("ovf_sp", 32'(sp), 32'd127);
    check("ovf_set", 32'(ovf), 32'd1);
    do_pop(16'd126);
    check("pop_from_full_data", 32'(pop_data), 32'd126);
    check("pop_from_full_sp", 32'(sp), 32'd126);
    check("full_dropped", 32'(full), 32'd0);
    tick();
    check("ovf_sticky", 32'(ovf), 32'd1);
    // Clear discards a simultaneous push
    stack_op  = STACK_OP_PUSH;
    push_data = 16'hDEAD;
    do_clr();
    stack_op  = STACK_OP_NOP;
    check("clr_sp", 32'(sp), 32'd0);
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);

    // Push in N, pop in N+1
    do_push(16'hA5A5);
    do_pop(16'hA5A5);
    check("push_pop_valid", 32'(pop_valid), 32'd1);
    check("push_pop_data", 32'(pop_data), 32'hA5A5);

    // Pop in N, push in N+1 into the vacated slot
    do_push(16'h1234);
    do_push(16'h5678);
    do_pop(16'h5678);
    do_push(16'h9ABC);
    check("pop_push_data_kept", 32'(pop_data), 32'h5678);
    check("pop_push_sp", 32'(sp), 32'd2);
    do_pop(16'h9ABC);
    do_pop(16'h1234);
    tick();

    // Reset mid-pop: the pending result is lost
    do_push(16'h7777);
    stack_op = STACK_OP_POP;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_mid_sp", 32'(sp), 32'd0);
    check("rst_mid_pop_valid", 32'(pop_valid), 32'd0);
    stack_op = STACK_OP_NOP;
    repeat (2) tick();
    check("rst_hold_pop_valid", 32'(pop_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("rst_release_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_release_sp", 32'(sp), 32'd0);
    do_push(16'h0042);
    do_pop(16'h0042);
    check("post_rst_pop_data", 32'(pop_data), 32'h0042);
    tick();

    // Drain: every expected pop must have been seen
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
